// File: rtl/clic_dispatch.sv
// ---------------------------------------------------------------------------
// clic_dispatch
// Sits directly behind the CLIC priority arbiter. Decides whether the
// arbiter's winning vector preempts the running priority level, hands it to
// the core with a req/ack handshake, clears the taken vector's pending bit
// and keeps a nesting stack of preempted levels, popped on handler exit.
//
// Optional feature macro: CLIC_TAIL_CHAIN_EN
//   defined   : on an exit while IDLE, the preempt check uses the popped level,
//               so a waiting vector is requested on the same edge as the pop.
//   undefined : the preempt check always uses the registered cur_prio.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_reset        synchronous active-high reset
//   i_cand_valid   arbiter has an enabled pending winner
//   i_cand_index   winning vector index
//   i_cand_prio    winning vector priority
//   o_irq_req      interrupt request to core
//   o_irq_index    requested vector (may be upgraded while requesting)
//   o_irq_prio     requested priority
//   i_irq_ack      core takes the request
//   i_irq_exit     core leaves the current handler (1-cycle pulse)
//   o_clr_pending  1-cycle pulse, clear pending bit of o_clr_index
//   o_clr_index    vector whose pending bit is cleared
//   o_cur_prio     running priority level, 0 = no handler active
//   o_nest_depth   number of stacked levels
//   o_proto_err    sticky protocol error flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no request outstanding, evaluating arbiter candidate
// ST_REQ   | request presented to core, waiting for ack / withdraw
// ---------------------------------------------------------------------------

package common_pkg;
    localparam int NR_PRIO_BITS  = 3;
    localparam int NR_INDEX_BITS = 5;
endpackage

module clic_dispatch #(
    parameter int PRIO_W      = common_pkg::NR_PRIO_BITS,
    parameter int IDX_W       = common_pkg::NR_INDEX_BITS,
    parameter int STACK_DEPTH = 2**common_pkg::NR_PRIO_BITS - 1,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cand_valid,
    input  logic [IDX_W-1:0]  i_cand_index,
    input  logic [PRIO_W-1:0] i_cand_prio,
    output logic              o_irq_req,
    output logic [IDX_W-1:0]  o_irq_index,
    output logic [PRIO_W-1:0] o_irq_prio,
    input  logic              i_irq_ack,
    input  logic              i_irq_exit,
    output logic              o_clr_pending,
    output logic [IDX_W-1:0]  o_clr_index,
    output logic [PRIO_W-1:0] o_cur_prio,
    output logic [DW-1:0]     o_nest_depth,
    output logic              o_proto_err
);

    localparam int             SW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0]  LP_FULL = DW'(STACK_DEPTH);

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [IDX_W-1:0]  index_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    index_t         r_irq_index;
    index_t         w_irq_index_nxt;
    prio_t          r_irq_prio;
    prio_t          w_irq_prio_nxt;
    prio_t          r_cur_prio;
    logic [DW-1:0]  r_depth;
    prio_t          r_stack [STACK_DEPTH];
    logic           r_clr_pending;
    index_t         r_clr_index;
    logic           r_proto_err;

    logic           w_ack_take;
    logic           w_pop;
    logic           w_push;
    logic [SW-1:0]  w_push_idx;
    logic [SW-1:0]  w_pop_idx;
    prio_t          w_top;
    prio_t          w_thr;
    logic [DW-1:0]  w_room_depth;
    logic           w_preempt;
    logic           w_err_evt;

    // An ack only counts while a request is actually outstanding; when it
    // lands together with an exit the exit is dropped so push and pop never
    // collide on the same edge.
    assign w_ack_take = (r_state == ST_REQ) && i_irq_ack;
    assign w_pop      = i_irq_exit && !w_ack_take && (r_depth != '0);
    assign w_push_idx = SW'(r_depth);
    assign w_pop_idx  = SW'(r_depth - 1'b1);
    assign w_top      = r_stack[w_pop_idx];

`ifdef CLIC_TAIL_CHAIN_EN
    assign w_thr        = w_pop ? w_top : r_cur_prio;
    assign w_room_depth = w_pop ? (r_depth - 1'b1) : r_depth;
`else
    assign w_thr        = r_cur_prio;
    assign w_room_depth = r_depth;
`endif

    // Unsigned compare: a prio-0 candidate can never exceed any threshold.
    assign w_preempt = i_cand_valid && (i_cand_prio > w_thr) && (w_room_depth < LP_FULL);

    assign w_err_evt = (i_irq_ack && (r_state != ST_REQ))
                     || (i_irq_exit && (w_ack_take || (r_depth == '0)));

    always_comb begin
        w_state_nxt     = r_state;
        w_irq_index_nxt = r_irq_index;
        w_irq_prio_nxt  = r_irq_prio;
        w_push          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_preempt) begin
                    w_state_nxt     = ST_REQ;
                    w_irq_index_nxt = i_cand_index;
                    w_irq_prio_nxt  = i_cand_prio;
                end
            end
            ST_REQ: begin
                if (i_irq_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!i_cand_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_cand_prio > r_irq_prio) begin
                    w_irq_index_nxt = i_cand_index;
                    w_irq_prio_nxt  = i_cand_prio;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_index   <= '0;
            r_irq_prio    <= '0;
            r_cur_prio    <= '0;
            r_depth       <= '0;
            r_clr_pending <= 1'b0;
            r_clr_index   <= '0;
            r_proto_err   <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
        end else begin
            r_irq_index   <= w_irq_index_nxt;
            r_irq_prio    <= w_irq_prio_nxt;
            r_clr_pending <= w_push;
            if (w_push) begin
                r_stack[w_push_idx] <= r_cur_prio;
                r_cur_prio          <= r_irq_prio;
                r_depth             <= r_depth + 1'b1;
                r_clr_index         <= r_irq_index;
            end else if (w_pop) begin
                r_cur_prio <= w_top;
                r_depth    <= r_depth - 1'b1;
            end
            if (w_err_evt) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_irq_req     = (r_state == ST_REQ);
    assign o_irq_index   = r_irq_index;
    assign o_irq_prio    = r_irq_prio;
    assign o_clr_pending = r_clr_pending;
    assign o_clr_index   = r_clr_index;
    assign o_cur_prio    = r_cur_prio;
    assign o_nest_depth  = r_depth;
    assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_clic_dispatch.sv
module tb_clic_dispatch;

    localparam int DEPTH = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv;
    logic [4:0] ci;
    logic [2:0] cp;
    logic       ack;
    logic       ex;

    logic       irq_req;
    logic [4:0] irq_index;
    logic [2:0] irq_prio;
    logic       clr_pending;
    logic [4:0] clr_index;
    logic [2:0] cur_prio;
    logic [2:0] nest_depth;
    logic       proto_err;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit m_req;
    int m_idx, m_prio, m_cur, m_clr_idx;
    bit m_clr, m_err;
    int m_stk[$];

    always #5 clk = ~clk;

    clic_dispatch dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cand_valid (cv),
        .i_cand_index (ci),
        .i_cand_prio  (cp),
        .o_irq_req    (irq_req),
        .o_irq_index  (irq_index),
        .o_irq_prio   (irq_prio),
        .i_irq_ack    (ack),
        .i_irq_exit   (ex),
        .o_clr_pending(clr_pending),
        .o_clr_index  (clr_index),
        .o_cur_prio   (cur_prio),
        .o_nest_depth (nest_depth),
        .o_proto_err  (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int i, input int p, input bit a, input bit e);
        cv  = v;
        ci  = 5'(i);
        cp  = 3'(p);
        ack = a;
        ex  = e;
    endtask

    // One rising edge of the reference: rules applied with a queue as the stack.
    task automatic model_edge();
        bit take, pop;
        int thr, room, top;
        if (rst) begin
            m_req = 0; m_idx = 0; m_prio = 0; m_cur = 0;
            m_clr = 0; m_clr_idx = 0; m_err = 0;
            m_stk.delete();
            return;
        end
        take = m_req && ack;
        if ((ack && !m_req) || (ex && (take || m_stk.size() == 0))) m_err = 1;
        pop   = ex && !take && (m_stk.size() > 0);
        m_clr = take;
        if (take) begin
            m_stk.push_back(m_cur);
            m_cur     = m_prio;
            m_clr_idx = m_idx;
            m_req     = 0;
        end else begin
            thr  = m_cur;
            room = m_stk.size();
            if (pop) begin
                top   = m_stk.pop_back();
                m_cur = top;
`ifdef CLIC_TAIL_CHAIN_EN
                thr  = top;
                room = m_stk.size();
`endif
            end
            if (m_req) begin
                if (!cv) m_req = 0;
                else if (int'(cp) > m_prio) begin
                    m_idx  = ci;
                    m_prio = cp;
                end
            end else if (cv && int'(cp) > thr && room < DEPTH) begin
                m_req  = 1;
                m_idx  = ci;
                m_prio = cp;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("irq_req",     32'(irq_req),     32'(m_req));
        check("irq_index",   32'(irq_index),   32'(m_idx));
        check("irq_prio",    32'(irq_prio),    32'(m_prio));
        check("clr_pending", 32'(clr_pending), 32'(m_clr));
        check("clr_index",   32'(clr_index),   32'(m_clr_idx));
        check("cur_prio",    32'(cur_prio),    32'(m_cur));
        check("nest_depth",  32'(nest_depth),  32'(m_stk.size()));
        check("proto_err",   32'(proto_err),   32'(m_err));
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 5, 3, 0, 0);

        // reset held two cycles with a valid candidate
        step();
        check("rst_req_a", 32'(irq_req), 0);
        step();
        check("rst_req_b", 32'(irq_req), 0);
        check("rst_cur", 32'(cur_prio), 0);
        check("rst_depth", 32'(nest_depth), 0);
        check("rst_err", 32'(proto_err), 0);
        check("rst_clr", 32'(clr_pending), 0);
        rst = 1'b0;

        // take
        step();
        check("take_req", 32'(irq_req), 1);
        check("take_idx", 32'(irq_index), 5);
        drive(0, 0, 0, 1, 0);
        step();
        check("take_clr", 32'(clr_pending), 1);
        check("take_clr_idx", 32'(clr_index), 5);
        check("take_cur", 32'(cur_prio), 3);
        check("take_depth", 32'(nest_depth), 1);

        // nest
        drive(1, 2, 2, 0, 0);
        step();
        check("nest_low_noreq", 32'(irq_req), 0);
        check("nest_clr_pulse", 32'(clr_pending), 0);
        drive(1, 9, 6, 0, 0);
        step();
        check("nest_req", 32'(irq_req), 1);
        check("nest_idx", 32'(irq_index), 9);
        drive(0, 0, 0, 1, 0);
        step();
        check("nest_cur", 32'(cur_prio), 6);
        check("nest_depth", 32'(nest_depth), 2);
        drive(0, 0, 0, 0, 1);
        step();
        check("exit1_cur", 32'(cur_prio), 3);
        check("exit1_depth", 32'(nest_depth), 1);
        step();
        check("exit2_cur", 32'(cur_prio), 0);
        check("exit2_depth", 32'(nest_depth), 0);

        // upgrade / withdraw
        drive(1, 5, 3, 0, 0);
        step();
        check("upg_req", 32'(irq_index), 5);
        drive(1, 7, 5, 0, 0);
        step();
        check("upg_idx", 32'(irq_index), 7);
        check("upg_prio", 32'(irq_prio), 5);
        check("upg_req_held", 32'(irq_req), 1);
        drive(0, 0, 0, 0, 0);
        step();
        check("wd_req", 32'(irq_req), 0);
        check("wd_clr", 32'(clr_pending), 0);

        // protocol errors
        drive(0, 0, 0, 0, 1);
        step();
        check("err_exit0", 32'(proto_err), 1);
        check("err_exit0_cur", 32'(cur_prio), 0);
        drive(1, 5, 3, 0, 0);
        step();
        drive(1, 5, 3, 1, 1);
        step();
        check("ackexit_clr", 32'(clr_pending), 1);
        check("ackexit_cur", 32'(cur_prio), 3);
        check("ackexit_depth", 32'(nest_depth), 1);
        check("ackexit_err", 32'(proto_err), 1);

        // tail chain: depth 1, cur 3, low candidate waiting
        drive(1, 4, 2, 0, 0);
        step();
        check("tc_wait", 32'(irq_req), 0);
        drive(1, 4, 2, 0, 1);
        step();
`ifdef CLIC_TAIL_CHAIN_EN
        check("tc_n1", 32'(irq_req), 1);
`else
        check("tc_n1", 32'(irq_req), 0);
`endif
        check("tc_pop_cur", 32'(cur_prio), 0);
        drive(1, 4, 2, 0, 0);
        step();
        check("tc_n2", 32'(irq_req), 1);
        check("tc_idx", 32'(irq_index), 4);
        drive(0, 0, 0, 1, 0);
        step();
        check("tc_cur", 32'(cur_prio), 2);

        // reset mid-handshake
        drive(1, 6, 4, 0, 0);
        step();
        check("mid_req", 32'(irq_req), 1);
        rst = 1'b1;
        drive(1, 6, 4, 1, 0);
        step();
        check("mid_rst_req", 32'(irq_req), 0);
        check("mid_rst_clr", 32'(clr_pending), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            cv  = ($urandom_range(0, 3) != 0);
            ci  = 5'($urandom_range(0, 31));
            cp  = 3'($urandom_range(0, 7));
            ack = m_req ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            ex  = (m_stk.size() > 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
